alu_result_stage: RTL



---
 rtl/alu_result_stage_pkg.sv | 34 +++
 rtl/skid_buf2.sv | 49 ++++
 rtl/alu_result_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU result-stage types: op codes, NZCV bit positions, buffered entry layout.
// No logic here; imported by the buffer and the top-level stage.
package alu_pkg;

    localparam int RES_DATA_W = 16;
    localparam int RES_TAG_W  = 4;

    typedef enum logic [2:0] {
        ALU_SUB  = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_MUL  = 3'b010,
        ALU_DIV3 = 3'b011,
        ALU_AND  = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHR  = 3'b110,
        ALU_ILL  = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [RES_DATA_W-1:0] result;
        logic [RES_TAG_W-1:0]  rd;
    } res_entry_t;

    // Only arithmetic ops produce a meaningful carry/overflow.
    function automatic logic op_loads_cv(input alu_op_e op);
        return (op == ALU_SUB) || (op == ALU_ADD);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO of res_entry_t; head/tail exposed combinationally from storage.
// Latency: push at edge t is readable at head from t+1; caller must never push when full.
module skid_buf2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  res_entry_t i_dat,
    output res_entry_t o_head,
    output res_entry_t o_tail,
    output logic [1:0] o_count
);

    res_entry_t r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write pointer names the next free slot, so the youngest entry sits behind it.
    assign o_head  = r_mem[r_rd_ptr];
    assign o_tail  = r_mem[~r_wr_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry elastic buffer to writeback, NZCV register, sticky illegal-op flag.
// Latency 1 cycle when empty; in_ready registered (count<2). RESULT_FWD_EN enables fwd_* bypass.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic [2:0]        alu_op,
    input  logic [TAG_W-1:0]  in_rd,
    input  logic              in_set_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_rd,
    output logic [3:0]        nzcv,
    output logic              illegal_op,
    output logic              fwd_valid,
    output logic [TAG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_result
);

    if (DEPTH != 2) begin : g_bad_depth
        $error("alu_result_stage: DEPTH must be 2");
    end
    if (DATA_W != RES_DATA_W || TAG_W != RES_TAG_W) begin : g_bad_width
        $error("alu_result_stage: DATA_W/TAG_W must match alu_pkg entry layout");
    end

`ifdef RESULT_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic       r_in_ready;
    logic [3:0] r_nzcv;
    logic       r_illegal;

    alu_op_e    w_op;
    logic       w_push;
    logic       w_ill;
    logic       w_enq;
    logic       w_pop;
    logic       w_out_valid;
    logic [1:0] w_count;
    logic [1:0] w_count_nxt;
    res_entry_t w_in_entry;
    res_entry_t w_head;
    res_entry_t w_tail;

    assign w_op        = alu_op_e'(alu_op);
    assign w_push      = in_valid & r_in_ready;
    assign w_ill       = (w_op == ALU_ILL);
    assign w_enq       = w_push & ~w_ill;
    assign w_out_valid = (w_count != 2'd0);
    assign w_pop       = w_out_valid & out_ready;

    assign w_in_entry.result = alu_result;
    assign w_in_entry.rd     = in_rd;

    skid_buf2 u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_enq),
        .i_pop   (w_pop),
        .i_dat   (w_in_entry),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_count (w_count)
    );

    always_comb begin
        w_count_nxt = w_count;
        case ({w_enq, w_pop})
            2'b10:   w_count_nxt = w_count + 2'd1;
            2'b01:   w_count_nxt = w_count - 2'd1;
            default: w_count_nxt = w_count;
        endcase
    end

    // Flags follow program order at push time, independent of writeback stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b1;
            r_nzcv     <= 4'b0000;
            r_illegal  <= 1'b0;
        end else begin
            r_in_ready <= (w_count_nxt != 2'd2);
            if (w_push && w_ill) begin
                r_illegal <= 1'b1;
            end
            if (w_enq && in_set_flags) begin
                r_nzcv[FLAG_N] <= alu_result[DATA_W-1];
                r_nzcv[FLAG_Z] <= (alu_result == '0);
                if (op_loads_cv(w_op)) begin
                    r_nzcv[FLAG_C] <= alu_carry;
                    r_nzcv[FLAG_V] <= alu_overflow;
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = w_out_valid;
    assign out_result = w_head.result;
    assign out_rd     = w_head.rd;
    assign nzcv       = r_nzcv;
    assign illegal_op = r_illegal;

    assign fwd_valid  = FWD_EN & w_out_valid;
    assign fwd_rd     = fwd_valid ? w_tail.rd     : '0;
    assign fwd_result = fwd_valid ? w_tail.result : '0;

endmodule
